// File: rtl/ad9226_mc_capture.sv
// Multi-channel AD9226 capture: synchronises clk_sample, settles after each falling edge,
// latches every channel at once and averages 2^k captures into one AXI-Stream beat.

module ad9226_mc_capture_lane #(
  parameter int W            = 12,
  parameter int MAX_AVG_LOG2 = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cap,
  input  logic         first,
  input  logic [2:0]   k,
  input  logic [W-1:0] sample,
  output logic [W-1:0] avg
);
  localparam int AW = W + MAX_AVG_LOG2;

  logic [AW-1:0] acc_q, sum;

  // first capture of a frame restarts the sum, so the accumulator never needs clearing
  assign sum = (first ? '0 : acc_q) + AW'(sample);
  assign avg = W'(sum >> k);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc_q <= '0;
    else if (cap) acc_q <= sum;
  end
endmodule

module ad9226_mc_capture #(
  parameter int ADC_DATA_WIDTH = 12,
  parameter int NUM_CH         = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int SETTLE_CYCLES  = 2,
  parameter int MAX_AVG_LOG2   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         clk_sample,
  input  logic                         ready,
  input  logic [2:0]                   avg_log2,
  input  logic [NUM_CH*ADC_DATA_WIDTH-1:0] data_in,
  output logic [NUM_CH*ADC_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tuser,
  output logic                         eoc,
  output logic                         overrun,
  input  logic                         clr_overrun
);
  localparam int W  = ADC_DATA_WIDTH;
  localparam int CW = (MAX_AVG_LOG2 > 0) ? MAX_AVG_LOG2 : 1;
  localparam logic [3:0] SET_LAST = 4'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [2:0] K_MAX    = 3'(MAX_AVG_LOG2);

  typedef enum logic [2:0] {IDLE, WAIT_RISE, WAIT_FALL, SETTLE, CAPTURE} state_t;
  typedef struct packed {
    logic                   user;
    logic [NUM_CH-1:0][W-1:0] data;
  } beat_t;

  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES:0]   warm_q;
  logic                   s, s_d, primed;
  logic [3:0]             scnt_q;
  logic [CW-1:0]          cnt_q;
  logic [2:0]             k_q, k_clamp, k_eff;
  logic                   inv_q, inv_nxt, first, last, cap, frame_done;
  logic                   load, drop;
  logic [NUM_CH-1:0][W-1:0] din, avg;
  beat_t                  beat_q;
  logic                   beat_vld_q, eoc_q, overrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      s_d    <= 1'b1;
      warm_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk_sample};
      s_d    <= s;
      warm_q <= {warm_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];
  // the synchroniser resets to 1; leaving IDLE only once it has flushed keeps that
  // fake high level from being read as a real high->low transition
  assign primed = warm_q[SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      scnt_q  <= (state_q == SETTLE) ? scnt_q + 4'd1 : 4'd0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (primed) state_d = WAIT_RISE;
      WAIT_RISE: if (s) state_d = WAIT_FALL;
      WAIT_FALL: if (!s && s_d) state_d = (SETTLE_CYCLES == 0) ? CAPTURE : SETTLE;
      SETTLE:    if (scnt_q == SET_LAST) state_d = CAPTURE;
      CAPTURE:   state_d = WAIT_RISE;
      default:   state_d = IDLE;
    endcase
    if (!enable) state_d = IDLE;
  end

  assign cap        = (state_q == CAPTURE) && enable;
  assign first      = (cnt_q == '0);
  assign k_clamp    = (avg_log2 > K_MAX) ? K_MAX : avg_log2;
  assign k_eff      = first ? k_clamp : k_q;
  assign last       = (8'(cnt_q) == ((8'd1 << k_eff) - 8'd1));
  assign frame_done = cap && last;
  assign inv_nxt    = (!first && inv_q) || !ready;
  assign din        = data_in;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    ad9226_mc_capture_lane #(.W(W), .MAX_AVG_LOG2(MAX_AVG_LOG2)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .cap    (cap),
      .first  (first),
      .k      (k_eff),
      .sample (ready ? din[i] : '0),
      .avg    (avg[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      k_q   <= '0;
      inv_q <= 1'b0;
      eoc_q <= 1'b0;
    end else begin
      eoc_q <= cap;
      if (!enable)  cnt_q <= '0;
      else if (cap) cnt_q <= last ? '0 : cnt_q + CW'(1);
      if (cap && first) k_q <= k_clamp;
      if (cap) inv_q <= inv_nxt;
    end
  end

  // single-entry output register; a frame finishing against a stalled beat is dropped
  assign load = frame_done && (!beat_vld_q || m_axis_tready);
  assign drop = frame_done && beat_vld_q && !m_axis_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q     <= '0;
      beat_vld_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      if (load) begin
        beat_q.data <= avg;
        beat_q.user <= inv_nxt;
        beat_vld_q  <= 1'b1;
      end else if (m_axis_tready) begin
        beat_vld_q  <= 1'b0;
      end
      if (drop)             overrun_q <= 1'b1;
      else if (clr_overrun) overrun_q <= 1'b0;
    end
  end

  assign m_axis_tdata  = beat_q.data;
  assign m_axis_tuser  = beat_q.user;
  assign m_axis_tvalid = beat_vld_q;
  assign eoc           = eoc_q;
  assign overrun       = overrun_q;
endmodule
